// File: rtl/pixel_line_buf.sv
// Frames a gated pixel stream into NUM_PIXEL-pixel lines (SOL/EOL tags) and buffers them in a FWFT FIFO.
// Optional build macro PIXEL_LINE_SUM_EN adds a per-line unsigned pixel sum on LINE_SUM.
module pixel_line_buf #(
    parameter int pixelWidth = 16,
    parameter int NUM_PIXEL  = 16,
    parameter int DEPTH      = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  CLR,
    input  logic                  PIXEL_VALID,
    input  logic [pixelWidth-1:0] PIXEL_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [pixelWidth-1:0] OUT_DATA,
    output logic                  OUT_SOL,
    output logic                  OUT_EOL,
    output logic                  LINE_DONE,
    output logic                  LINE_ERR,
    output logic [15:0]           LINE_CNT,
    output logic                  OVERFLOW
`ifdef PIXEL_LINE_SUM_EN
    ,
    output logic [pixelWidth+7:0] LINE_SUM
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int IW = $clog2(NUM_PIXEL);
    localparam int EW = pixelWidth + 2;

    typedef enum logic {eIdle, eLine} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic            line_done_q, line_done_d;
    logic            line_err_q, line_err_d;
    logic [15:0]     line_cnt_q, line_cnt_d;
    logic            overflow_q, overflow_d;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   head;
    logic            empty, full, do_read, do_write, pix_sol, pix_eol;

    always_comb begin
        empty    = (rd_ptr_q == wr_ptr_q);
        full     = (rd_ptr_q[AW] != wr_ptr_q[AW]) && (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
        pix_sol  = (idx_q == '0);
        pix_eol  = (idx_q == IW'(NUM_PIXEL - 1));
        do_read  = OUT_READY && !empty && !CLR;
        // A full FIFO still takes the pixel when the head leaves in the same cycle.
        do_write = PIXEL_VALID && (!full || do_read) && !CLR;

        state_d     = state_q;
        idx_d       = idx_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        line_done_d = 1'b0;
        line_err_d  = 1'b0;
        line_cnt_d  = line_cnt_q;
        overflow_d  = overflow_q;

        if (CLR) begin
            state_d    = eIdle;
            idx_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            line_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_read)
                rd_ptr_d = rd_ptr_q + PW'(1);
            if (do_write)
                wr_ptr_d = wr_ptr_q + PW'(1);
            if (PIXEL_VALID && !do_write)
                overflow_d = 1'b1;

            if (PIXEL_VALID) begin
                state_d = eLine;
                if (pix_eol) begin
                    idx_d       = '0;
                    line_done_d = 1'b1;
                    line_cnt_d  = line_cnt_q + 16'd1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end else if (state_q == eLine) begin
                line_err_d = (idx_q != '0);
                idx_d      = '0;
                state_d    = eIdle;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= eIdle;
            idx_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            line_done_q <= 1'b0;
            line_err_q  <= 1'b0;
            line_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            line_done_q <= line_done_d;
            line_err_q  <= line_err_d;
            line_cnt_q  <= line_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_write)
            mem_q[wr_ptr_q[AW-1:0]] <= {pix_sol, pix_eol, PIXEL_DATA};
    end

    // Storage is never reset, so the head is masked to zero while the FIFO is empty.
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign OUT_VALID = !empty;
    assign OUT_DATA  = empty ? '0 : head[pixelWidth-1:0];
    assign OUT_EOL   = empty ? 1'b0 : head[pixelWidth];
    assign OUT_SOL   = empty ? 1'b0 : head[pixelWidth+1];
    assign LINE_DONE = line_done_q;
    assign LINE_ERR  = line_err_q;
    assign LINE_CNT  = line_cnt_q;
    assign OVERFLOW  = overflow_q;

`ifdef PIXEL_LINE_SUM_EN
    logic [pixelWidth+7:0] acc_q, acc_d, sum_q, sum_d, sum_next;

    always_comb begin
        sum_next = (pix_sol ? '0 : acc_q) + {8'd0, PIXEL_DATA};
        acc_d    = acc_q;
        sum_d    = sum_q;
        if (CLR) begin
            acc_d = '0;
        end else if (PIXEL_VALID) begin
            acc_d = sum_next;
            if (pix_eol)
                sum_d = sum_next;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

    assign LINE_SUM = sum_q;
`endif

endmodule

// File: tb/tb_pixel_line_buf.sv
// Directed bench for pixel_line_buf: a vector table for line framing plus hand sequences for overflow,
// full-FIFO pass-through, mid-line reset, and (with PIXEL_LINE_SUM_EN) the line sum.
module tb_pixel_line_buf;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        CLR = 1'b0;
    logic        PIXEL_VALID = 1'b0;
    logic [15:0] PIXEL_DATA = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [15:0] OUT_DATA;
    logic        OUT_SOL, OUT_EOL, LINE_DONE, LINE_ERR, OVERFLOW;
    logic [15:0] LINE_CNT;
`ifdef PIXEL_LINE_SUM_EN
    logic [23:0] LINE_SUM;
`endif

    pixel_line_buf #(.pixelWidth(16), .NUM_PIXEL(16), .DEPTH(32)) dut (
        .CLK(CLK), .nRST(nRST), .CLR(CLR),
        .PIXEL_VALID(PIXEL_VALID), .PIXEL_DATA(PIXEL_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .OUT_SOL(OUT_SOL), .OUT_EOL(OUT_EOL),
        .LINE_DONE(LINE_DONE), .LINE_ERR(LINE_ERR),
        .LINE_CNT(LINE_CNT), .OVERFLOW(OVERFLOW)
`ifdef PIXEL_LINE_SUM_EN
        , .LINE_SUM(LINE_SUM)
`endif
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic        pv;
        logic [15:0] pd;
        logic        v;
        logic [15:0] d;
        logic        sol, eol, done, err;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [30];
    logic [15:0] q [$];

    initial begin
        // Expected state after each edge, with OUT_READY=1 so the head is always the latest pixel.
        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 16'(i + 1), 1'b1, 16'(i + 1), i == 0, i == 15, i == 15, 1'b0,
                       (i == 15) ? 16'd1 : 16'd0};
        tbl[16] = '{1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        for (int j = 0; j < 10; j++)
            tbl[17 + j] = '{1'b1, 16'(16'h100 + j), 1'b1, 16'(16'h100 + j), j == 0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[27] = '{1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[28] = '{1'b1, 16'h200, 1'b1, 16'h200, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[29] = '{1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};

        step(); step();
        nRST = 1'b1;
        step();
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_data", OUT_DATA, 0);
        chk("rst_cnt", LINE_CNT, 0);
        chk("rst_ovf", OVERFLOW, 0);

        OUT_READY = 1'b1;
        for (int i = 0; i < 30; i++) begin
            PIXEL_VALID = tbl[i].pv;
            PIXEL_DATA  = tbl[i].pd;
            step();
            chk($sformatf("row%0d_valid", i), OUT_VALID, tbl[i].v);
            chk($sformatf("row%0d_data", i), OUT_DATA, tbl[i].d);
            chk($sformatf("row%0d_sol", i), OUT_SOL, tbl[i].sol);
            chk($sformatf("row%0d_eol", i), OUT_EOL, tbl[i].eol);
            chk($sformatf("row%0d_done", i), LINE_DONE, tbl[i].done);
            chk($sformatf("row%0d_err", i), LINE_ERR, tbl[i].err);
            chk($sformatf("row%0d_cnt", i), LINE_CNT, tbl[i].cnt);
        end

        // Overflow: clear, then 48 pixels with the consumer stalled.
        CLR = 1'b1; step(); CLR = 1'b0;
        chk("clr_cnt", LINE_CNT, 0);
        OUT_READY = 1'b0;
        for (int k = 0; k < 48; k++) begin
            PIXEL_VALID = 1'b1; PIXEL_DATA = 16'(16'h300 + k);
            step();
        end
        PIXEL_VALID = 1'b0;
        step();
        chk("ovf_flag", OVERFLOW, 1);
        chk("ovf_cnt", LINE_CNT, 3);
        OUT_READY = 1'b1;
        begin
            int n;
            n = 0;
            for (int c = 0; c < 40 && OUT_VALID; c++) begin
                chk($sformatf("drain%0d_data", n), OUT_DATA, 16'(16'h300 + n));
                chk($sformatf("drain%0d_sol", n), OUT_SOL, (n % 16) == 0);
                chk($sformatf("drain%0d_eol", n), OUT_EOL, (n % 16) == 15);
                n++;
                step();
            end
            chk("drain_count", n, 32);
        end

        // Mid-line async reset with data sitting in the FIFO.
        OUT_READY = 1'b0;
        for (int k = 0; k < 7; k++) begin
            PIXEL_VALID = 1'b1; PIXEL_DATA = 16'(16'h50 + k);
            step();
        end
        chk("pre_rst_valid", OUT_VALID, 1);
        PIXEL_VALID = 1'b0;
        #2 nRST = 1'b0;
        #1;
        chk("mid_rst_valid", OUT_VALID, 0);
        chk("mid_rst_data", OUT_DATA, 0);
        chk("mid_rst_sol", OUT_SOL, 0);
        chk("mid_rst_eol", OUT_EOL, 0);
        chk("mid_rst_done", LINE_DONE, 0);
        chk("mid_rst_err", LINE_ERR, 0);
        chk("mid_rst_cnt", LINE_CNT, 0);
        chk("mid_rst_ovf", OVERFLOW, 0);
        step(); step();
        nRST = 1'b1;
        OUT_READY = 1'b1;
        for (int k = 0; k < 16; k++) begin
            PIXEL_VALID = 1'b1; PIXEL_DATA = 16'(16'h500 + k);
            step();
            if (k == 0) begin
                chk("post_rst_sol", OUT_SOL, 1);
                chk("post_rst_first", OUT_DATA, 16'h500);
            end
        end
        chk("post_rst_eol", OUT_EOL, 1);
        chk("post_rst_done", LINE_DONE, 1);
        chk("post_rst_cnt", LINE_CNT, 1);
        PIXEL_VALID = 1'b0;
        step();
        chk("post_rst_noerr", LINE_ERR, 0);

        // Full FIFO with read and write together every cycle.
        CLR = 1'b1; step(); CLR = 1'b0;
        OUT_READY = 1'b0;
        for (int k = 0; k < 32; k++) begin
            PIXEL_VALID = 1'b1; PIXEL_DATA = 16'(16'h400 + k);
            q.push_back(PIXEL_DATA);
            step();
        end
        chk("full_ovf", OVERFLOW, 0);
        for (int k = 0; k < 20; k++) begin
            PIXEL_VALID = 1'b1; PIXEL_DATA = 16'(16'h420 + k); OUT_READY = 1'b1;
            step();
            void'(q.pop_front());
            q.push_back(16'(16'h420 + k));
            chk($sformatf("pass%0d_head", k), OUT_DATA, q[0]);
        end
        PIXEL_VALID = 1'b0;
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            chk($sformatf("pdrain%0d_valid", c), OUT_VALID, 1);
            chk($sformatf("pdrain%0d_data", c), OUT_DATA, q[0]);
            void'(q.pop_front());
            step();
        end
        chk("pass_empty", OUT_VALID, 0);
        chk("pass_ovf", OVERFLOW, 0);
        chk("pass_cnt", LINE_CNT, 3);

`ifdef PIXEL_LINE_SUM_EN
        for (int k = 0; k < 16; k++) begin
            PIXEL_VALID = 1'b1; PIXEL_DATA = 16'hFFFF;
            step();
        end
        chk("sum_ffff_done", LINE_DONE, 1);
        chk("sum_ffff", LINE_SUM, 24'h0FFFF0);
        for (int k = 0; k < 16; k++) begin
            PIXEL_VALID = 1'b1; PIXEL_DATA = 16'h0001;
            step();
            if (k == 7) chk("sum_hold", LINE_SUM, 24'h0FFFF0);
        end
        chk("sum_ones_done", LINE_DONE, 1);
        chk("sum_ones", LINE_SUM, 24'h10);
        PIXEL_VALID = 1'b0;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
